// File: rtl/spi_frame_ctrl.sv
// SPI slave frame sequencer: decodes command + data bursts per chip-select frame
// and hands register reads/writes to the system-clock bank via toggle events.
module spi_frame_ctrl #(
  parameter int NUM_REGS = 4,
  parameter int AUTO_INC = 1
) (
  input  logic       sclk,
  input  logic       rst_n,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic [6:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       wr_tgl,
  output logic       rd_tgl,
  input  logic [7:0] reg_rdata,
  output logic       err
);

  typedef enum logic [1:0] {
    ST_CMD   = 2'd0,
    ST_WDATA = 2'd1,
    ST_RDATA = 2'd2
  } state_t;

  localparam logic [7:0] NUM_W = 8'(NUM_REGS);
  localparam logic [6:0] INC_W = 7'(AUTO_INC);

  function automatic logic addr_ok(input logic [6:0] a);
    return ({1'b0, a} < NUM_W);
  endfunction

  state_t     state_r, state_s;
  logic [2:0] bit_cnt_r, bit_cnt_s;
  logic [7:0] rx_sh_r, rx_sh_s;
  logic [7:0] tx_sh_r, tx_sh_s;
  logic [6:0] ptr_r, ptr_s;
  logic       miso_r, miso_s;
  logic       pf_oor_r, pf_oor_s;
  logic       armed_r;
  logic       frame_rst_n_s;

  logic [6:0] reg_addr_r, reg_addr_s;
  logic [7:0] reg_wdata_r, reg_wdata_s;
  logic       wr_tgl_r, wr_tgl_s;
  logic       rd_tgl_r, rd_tgl_s;
  logic       err_r, err_s;

  logic [7:0] byte_s;
  logic       byte_done_s;
  logic [7:0] load_s;

  // A reset abandons the frame in progress; only a fresh cs_n fall re-arms it.
  always_ff @(negedge cs_n or negedge rst_n) begin
    if (!rst_n) begin
      armed_r <= 1'b0;
    end else begin
      armed_r <= 1'b1;
    end
  end

  assign frame_rst_n_s = rst_n & ~cs_n & armed_r;
  assign byte_s        = {rx_sh_r[6:0], mosi};
  assign byte_done_s   = (bit_cnt_r == 3'd7);
  assign load_s        = pf_oor_r ? 8'h00 : reg_rdata;

  // Next-state, shift and register-request decode.
  always_comb begin
    state_s     = state_r;
    bit_cnt_s   = bit_cnt_r + 3'd1;
    rx_sh_s     = byte_s;
    tx_sh_s     = {tx_sh_r[6:0], 1'b0};
    miso_s      = tx_sh_r[6];
    ptr_s       = ptr_r;
    pf_oor_s    = pf_oor_r;
    reg_addr_s  = reg_addr_r;
    reg_wdata_s = reg_wdata_r;
    wr_tgl_s    = wr_tgl_r;
    rd_tgl_s    = rd_tgl_r;
    err_s       = err_r;

    case (state_r)
      ST_CMD: begin
        miso_s = 1'b0;
        if (byte_done_s) begin
          if (byte_s[7]) begin
            state_s = ST_RDATA;
            ptr_s   = byte_s[6:0] + INC_W;
            if (addr_ok(byte_s[6:0])) begin
              reg_addr_s = byte_s[6:0];
              rd_tgl_s   = ~rd_tgl_r;
              pf_oor_s   = 1'b0;
            end else begin
              err_s    = 1'b1;
              pf_oor_s = 1'b1;
            end
          end else begin
            state_s = ST_WDATA;
            ptr_s   = byte_s[6:0];
          end
        end else begin
          state_s = ST_CMD;
        end
      end

      ST_WDATA: begin
        miso_s = 1'b0;
        if (byte_done_s) begin
          ptr_s = ptr_r + INC_W;
          if (addr_ok(ptr_r)) begin
            reg_addr_s  = ptr_r;
            reg_wdata_s = byte_s;
            wr_tgl_s    = ~wr_tgl_r;
          end else begin
            err_s = 1'b1;
          end
        end else begin
          state_s = ST_WDATA;
        end
      end

      ST_RDATA: begin
        // Load the byte prefetched one byte ago, then issue the next prefetch.
        if (byte_done_s) begin
          tx_sh_s = load_s;
          miso_s  = load_s[7];
          ptr_s   = ptr_r + INC_W;
          if (addr_ok(ptr_r)) begin
            reg_addr_s = ptr_r;
            rd_tgl_s   = ~rd_tgl_r;
            pf_oor_s   = 1'b0;
          end else begin
            err_s    = 1'b1;
            pf_oor_s = 1'b1;
          end
        end else begin
          state_s = ST_RDATA;
        end
      end

      default: begin
        state_s = ST_CMD;
        miso_s  = 1'b0;
      end
    endcase
  end

  // Frame state, cleared whenever the frame is not active.
  always_ff @(posedge sclk or negedge frame_rst_n_s) begin
    if (!frame_rst_n_s) begin
      state_r   <= ST_CMD;
      bit_cnt_r <= 3'd0;
      rx_sh_r   <= 8'h00;
      tx_sh_r   <= 8'h00;
      ptr_r     <= 7'd0;
      miso_r    <= 1'b0;
      pf_oor_r  <= 1'b0;
    end else begin
      state_r   <= state_s;
      bit_cnt_r <= bit_cnt_s;
      rx_sh_r   <= rx_sh_s;
      tx_sh_r   <= tx_sh_s;
      ptr_r     <= ptr_s;
      miso_r    <= miso_s;
      pf_oor_r  <= pf_oor_s;
    end
  end

  // Bank-facing request registers, persistent across frames.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      reg_addr_r  <= 7'd0;
      reg_wdata_r <= 8'h00;
      wr_tgl_r    <= 1'b0;
      rd_tgl_r    <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      reg_addr_r  <= reg_addr_s;
      reg_wdata_r <= reg_wdata_s;
      wr_tgl_r    <= wr_tgl_s;
      rd_tgl_r    <= rd_tgl_s;
      err_r       <= err_s;
    end
  end

  assign miso      = miso_r;
  assign reg_addr  = reg_addr_r;
  assign reg_wdata = reg_wdata_r;
  assign wr_tgl    = wr_tgl_r;
  assign rd_tgl    = rd_tgl_r;
  assign err       = err_r;

endmodule
